// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter that merges several writeback requesters onto the single register-file write port.
// Optional read-port bypass of the in-flight write is enabled by defining RF_WB_FWD_EN.
module rf_wb_arbiter #(
   parameter int NREQ = 3,
   parameter int AW   = 5,
   parameter int DW   = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 hold,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic                 rf_we,
   output logic [AW-1:0]        rf_wa3,
   output logic [DW-1:0]        rf_wd
`ifdef RF_WB_FWD_EN
   ,
   input  logic [AW-1:0]        ra1,
   input  logic [AW-1:0]        ra2,
   input  logic [DW-1:0]        rf_rd1,
   input  logic [DW-1:0]        rf_rd2,
   output logic [DW-1:0]        rd1,
   output logic [DW-1:0]        rd2
`endif
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] grant_idx;
   logic          found;
   logic          hs;
   logic          rf_we_q, rf_we_d;
   logic [AW-1:0] rf_wa3_q, rf_wa3_d;
   logic [DW-1:0] rf_wd_q, rf_wd_d;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_data;

   logic [AW-1:0] addr_arr [NREQ];
   logic [DW-1:0] data_arr [NREQ];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign addr_arr[gi] = req_addr[gi*AW +: AW];
         assign data_arr[gi] = req_data[gi*DW +: DW];
      end
   endgenerate

   // Scan requesters starting at ptr; one extra bit keeps ptr+k from overflowing before the wrap.
   always_comb begin
      logic [PW:0] sum;
      logic [PW-1:0] idx;
      found     = 1'b0;
      grant_idx = '0;
      sum       = '0;
      idx       = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, ptr_q} + (PW+1)'(k);
         if (sum >= (PW+1)'(NREQ)) begin
            sum = sum - (PW+1)'(NREQ);
         end
         idx = sum[PW-1:0];
         if (!found && req_valid[idx]) begin
            found     = 1'b1;
            grant_idx = idx;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      hs        = found && !hold && rst_n;
      if (hs) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   assign sel_addr = addr_arr[grant_idx];
   assign sel_data = data_arr[grant_idx];

   // Writes to register 0 are consumed but never reach the register file.
   always_comb begin
      ptr_d    = ptr_q;
      rf_we_d  = 1'b0;
      rf_wa3_d = rf_wa3_q;
      rf_wd_d  = rf_wd_q;
      if (hs) begin
         ptr_d = (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + PW'(1);
         if (sel_addr != '0) begin
            rf_we_d  = 1'b1;
            rf_wa3_d = sel_addr;
            rf_wd_d  = sel_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q    <= '0;
         rf_we_q  <= 1'b0;
         rf_wa3_q <= '0;
         rf_wd_q  <= '0;
      end else begin
         ptr_q    <= ptr_d;
         rf_we_q  <= rf_we_d;
         rf_wa3_q <= rf_wa3_d;
         rf_wd_q  <= rf_wd_d;
      end
   end

   assign rf_we  = rf_we_q;
   assign rf_wa3 = rf_wa3_q;
   assign rf_wd  = rf_wd_q;

`ifdef RF_WB_FWD_EN
   assign rd1 = (ra1 != '0 && rf_we_q && rf_wa3_q == ra1) ? rf_wd_q : rf_rd1;
   assign rd2 = (ra2 != '0 && rf_we_q && rf_wa3_q == ra2) ? rf_wd_q : rf_rd2;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed scenarios followed by random traffic against a
// rotation-order reference model; a negedge monitor checks grants and register-file writes.
module tb_rf_wb_arbiter;
   localparam int N  = 3;
   localparam int AW = 5;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            hold;
   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            rf_we;
   logic [AW-1:0]   rf_wa3;
   logic [DW-1:0]   rf_wd;
`ifdef RF_WB_FWD_EN
   logic [AW-1:0]   ra1, ra2;
   logic [DW-1:0]   rf_rd1, rf_rd2, rd1, rd2;
`endif

   rf_wb_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .hold      (hold),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rf_we     (rf_we),
      .rf_wa3    (rf_wa3),
      .rf_wd     (rf_wd)
`ifdef RF_WB_FWD_EN
      ,
      .ra1       (ra1),
      .ra2       (ra2),
      .rf_rd1    (rf_rd1),
      .rf_rd2    (rf_rd2),
      .rd1       (rd1),
      .rd2       (rd2)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
   typedef struct { int cyc; logic [N-1:0] r; } rdy_t;
   wr_t  wq[$];
   rdy_t rq[$];
   wr_t  we_e;
   rdy_t re_e;

   int errors = 0;
   int checks = 0;

   // Requester-side state and reference model
   bit            pend [N];
   logic [AW-1:0] paddr [N];
   logic [DW-1:0] pdata [N];
   int            mptr = 0;

   task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
      end
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   // Drive the requester state and predict this cycle's grant and next cycle's write.
   task automatic apply(input bit hld, input bit in_rst);
      logic [N-1:0] exp_r;
      int g;
      int j;
      hold = hld;
      for (int i = 0; i < N; i++) begin
         req_valid[i]           = pend[i];
         req_addr[i*AW +: AW]   = paddr[i];
         req_data[i*DW +: DW]   = pdata[i];
      end
      exp_r = '0;
      g = -1;
      if (!hld && !in_rst) begin
         for (int k = 0; k < N; k++) begin
            j = (mptr + k) % N;
            if (g < 0 && pend[j]) g = j;
         end
      end
      if (g >= 0) begin
         exp_r[g] = 1'b1;
         mptr = (g + 1) % N;
         pend[g] = 1'b0;
         if (paddr[g] != '0) wq.push_back('{cyc + 1, paddr[g], pdata[g]});
      end
      rq.push_back('{cyc, exp_r});
   endtask

   always @(negedge clk) begin
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
         re_e = rq.pop_front();
         checks++;
         if (req_ready !== re_e.r) begin
            errors++;
            $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, req_ready, re_e.r);
         end
      end
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
         we_e = wq.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_write cyc=%0d exp addr=%0d data=%h", we_e.cyc, we_e.a, we_e.d);
      end
      checks++;
      if (wq.size() > 0 && wq[0].cyc == cyc) begin
         we_e = wq.pop_front();
         if (rf_we !== 1'b1 || rf_wa3 !== we_e.a || rf_wd !== we_e.d) begin
            errors++;
            $display("FAIL write cyc=%0d got we=%b addr=%0d data=%h exp we=1 addr=%0d data=%h",
                     cyc, rf_we, rf_wa3, rf_wd, we_e.a, we_e.d);
         end else begin
            $display("write cyc=%0d addr=%0d data=%h", cyc, rf_wa3, rf_wd);
         end
      end else if (rf_we !== 1'b0) begin
         errors++;
         $display("FAIL spurious_write cyc=%0d got we=%b addr=%0d exp we=0", cyc, rf_we, rf_wa3);
      end
   end

   initial begin
      rst_n     = 1'b0;
      hold      = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      for (int i = 0; i < N; i++) begin
         pend[i]  = 1'b0;
         paddr[i] = '0;
         pdata[i] = '0;
      end
`ifdef RF_WB_FWD_EN
      ra1 = '0; ra2 = '0; rf_rd1 = '0; rf_rd2 = '0;
`endif
      repeat (2) @(posedge clk);
      #1;
      req_valid = '1;
      #1;
      chk("reset_ready", DW'(req_ready), '0);
      chk("reset_we",    DW'(rf_we),     '0);
      chk("reset_wa3",   DW'(rf_wa3),    '0);
      chk("reset_wd",    rf_wd,          '0);
      req_valid = '0;
      rst_n = 1'b1;

      // Single requester 1 to r5
      next_cycle;
      pend[1] = 1'b1; paddr[1] = 5'd5; pdata[1] = 32'hDEADBEEF;
      apply(1'b0, 1'b0);
      repeat (2) begin next_cycle; apply(1'b0, 1'b0); end

      // Write to r0 is consumed and dropped
      next_cycle;
      pend[2] = 1'b1; paddr[2] = 5'd0; pdata[2] = 32'h1234;
      apply(1'b0, 1'b0);
      next_cycle; apply(1'b0, 1'b0);

      // All requesters continuously valid
      for (int c = 0; c < 6; c++) begin
         next_cycle;
         for (int i = 0; i < N; i++) begin
            if (!pend[i]) begin
               pend[i] = 1'b1; paddr[i] = AW'(i + 1); pdata[i] = 32'hA000_0000 + 32'(c * 16 + i);
            end
         end
         apply(1'b0, 1'b0);
      end
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      repeat (2) begin next_cycle; apply(1'b0, 1'b0); end

      // Hold for three cycles, then release
      next_cycle;
      pend[0] = 1'b1; paddr[0] = 5'd10; pdata[0] = 32'h0A0A0A0A;
      pend[1] = 1'b1; paddr[1] = 5'd11; pdata[1] = 32'h0B0B0B0B;
      apply(1'b1, 1'b0);
      repeat (2) begin next_cycle; apply(1'b1, 1'b0); end
      repeat (3) begin next_cycle; apply(1'b0, 1'b0); end

      // Asynchronous reset while a registered write is in flight
      next_cycle;
      pend[1] = 1'b1; paddr[1] = 5'd9; pdata[1] = 32'h55;
      apply(1'b0, 1'b0);
      next_cycle;
      rst_n = 1'b0;
      #1;
      chk("async_reset_we", DW'(rf_we), '0);
      if (wq.size() > 0 && wq[$].cyc == cyc) void'(wq.pop_back());
      pend[0] = 1'b1; paddr[0] = 5'd12; pdata[0] = 32'h12;
      pend[2] = 1'b1; paddr[2] = 5'd14; pdata[2] = 32'h14;
      apply(1'b0, 1'b1);
      next_cycle; apply(1'b0, 1'b1);
      next_cycle;
      rst_n = 1'b1;
      mptr  = 0;
      apply(1'b0, 1'b0);
      repeat (3) begin next_cycle; apply(1'b0, 1'b0); end

`ifdef RF_WB_FWD_EN
      next_cycle;
      pend[0] = 1'b1; paddr[0] = 5'd7; pdata[0] = 32'hCAFEF00D;
      apply(1'b0, 1'b0);
      next_cycle;
      ra1 = 5'd7; rf_rd1 = '0; ra2 = 5'd0; rf_rd2 = 32'h1111_2222;
      #1;
      chk("fwd_rd1", rd1, 32'hCAFEF00D);
      chk("fwd_rd2", rd2, 32'h1111_2222);
      apply(1'b0, 1'b0);
`endif

      // Random traffic
      repeat (400) begin
         next_cycle;
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 99) < 50) begin
               pend[i]  = 1'b1;
               paddr[i] = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(1, 31));
               pdata[i] = $urandom;
            end
         end
         apply($urandom_range(0, 99) < 15, 1'b0);
      end

      // Drain outstanding requests
      repeat (N + 3) begin next_cycle; apply(1'b0, 1'b0); end
      next_cycle;
      chk("drain_ready_q", DW'(rq.size()), '0);
      chk("drain_write_q", DW'(wq.size()), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
